// File: rtl/package_framer_if.sv
// Byte-stream handshake between the framer and its TX sink (UART/GSM/Bluetooth).
interface package_framer_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/package_framer.sv
// Telemetry framer: snapshots child status and GPS coordinates on a start event and
// streams header, status, latitude, longitude (MSB byte first) and an optional XOR
// checksum over a valid/ready byte interface. Starts come from a periodic tick or send_req.
module package_framer #(
    parameter int unsigned COORD_W     = 32,
    parameter int unsigned PERIOD      = 32'd50_000_000,
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter bit          CHECKSUM_EN = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         child,
    input  logic [COORD_W-1:0] latitude,
    input  logic [COORD_W-1:0] longitude,
    input  logic               send_req,
    package_framer_if.master   tx,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun
);

    localparam int unsigned NBYTES = COORD_W / 8;
    localparam int unsigned IDX_W  = $clog2(NBYTES) + 1;

    typedef enum logic [2:0] {
        StIdle, StHdr, StChild, StLat, StLon, StCsum, StDone
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         csum_q, csum_d;
    logic [7:0]         child_q;
    logic [COORD_W-1:0] lat_q, lon_q;
    logic [31:0]        tick_cnt_q;
    logic [7:0]         data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;
    logic               busy_q, frame_done_q;
    logic               snap_en, tick, start, xfer, last_byte;

    // Byte i of a coordinate word, counting from the most significant byte.
    function automatic logic [7:0] coord_byte(input logic [COORD_W-1:0] w,
                                              input logic [IDX_W-1:0] i);
        logic [COORD_W-1:0] s;
        s = w >> (8 * (NBYTES - 1 - int'(i)));
        return s[7:0];
    endfunction

    assign tick      = (PERIOD != 0) && (tick_cnt_q == 32'(PERIOD - 1));
    assign start     = tick | send_req;
    assign xfer      = data_valid_q & tx.data_ready;
    assign last_byte = (idx_q == IDX_W'(NBYTES - 1));
    // A start that arrives while a frame is in flight is dropped and flagged in the same cycle.
    assign overrun   = start && (state_q != StIdle);

    assign tx.data_out   = data_out_q;
    assign tx.data_valid = data_valid_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;

    // Free-running auto-start counter, independent of frame state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (PERIOD == 0 || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 32'd1;
        end
    end

    // Next-state, byte index, running checksum and the registered output byte.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        csum_d       = csum_q;
        snap_en      = 1'b0;
        data_out_d   = '0;
        data_valid_d = 1'b1;
        unique case (state_q)
            StIdle: if (start) begin
                state_d = StHdr;
                csum_d  = '0;
                snap_en = 1'b1;
            end
            StHdr: if (xfer) state_d = StChild;
            StChild: if (xfer) begin
                csum_d  = csum_q ^ data_out_q;
                state_d = StLat;
                idx_d   = '0;
            end
            StLat: if (xfer) begin
                csum_d = csum_q ^ data_out_q;
                if (last_byte) begin
                    state_d = StLon;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StLon: if (xfer) begin
                csum_d = csum_q ^ data_out_q;
                if (last_byte) state_d = CHECKSUM_EN ? StCsum : StDone;
                else           idx_d   = idx_q + IDX_W'(1);
            end
            StCsum: if (xfer) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Outputs are computed from the next state so they are registered yet on time;
        // with no transfer the same byte is recomputed, keeping data_out stable.
        case (state_d)
            StHdr:   data_out_d = HEADER;
            StChild: data_out_d = child_q;
            StLat:   data_out_d = coord_byte(lat_q, idx_d);
            StLon:   data_out_d = coord_byte(lon_q, idx_d);
            StCsum:  data_out_d = csum_d;
            default: data_valid_d = 1'b0;
        endcase
    end

    // State, snapshot and output registers; reset discards any partial frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            csum_q       <= '0;
            child_q      <= '0;
            lat_q        <= '0;
            lon_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= (state_d != StIdle);
            frame_done_q <= (state_d == StDone);
            if (snap_en) begin
                child_q <= child;
                lat_q   <= latitude;
                lon_q   <= longitude;
            end
        end
    end

endmodule
